// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch resolve queue: entry layout and
// the saturating-increment enable used by every statistics counter.
package bp_pkg;

  // Default branch address width, matching saturating_predictor.
  localparam int unsigned ADDR_W = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
  } entry_t;

  // A counter may only advance when asked to and not already at its ceiling.
  function automatic logic sat_inc_en(input logic inc, input logic at_max);
    return inc & ~at_max;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Prediction, resolution and predictor-update channels of the branch resolve queue.
interface branch_resolve_queue_if #(
  parameter int unsigned ADDR_W = 1
);

  logic              pred_valid;
  logic [ADDR_W-1:0] pred_addr;
  logic              pred_taken;
  logic              pred_ready;

  logic              res_valid;
  logic              res_taken;
  logic              res_ready;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_result;
  logic              mispredict;

  modport master (
    output pred_valid, pred_addr, pred_taken, res_valid, res_taken,
    input  pred_ready, res_ready, upd_valid, upd_addr, upd_result, mispredict
  );

  modport slave (
    input  pred_valid, pred_addr, pred_taken, res_valid, res_taken,
    output pred_ready, res_ready, upd_valid, upd_addr, upd_result, mispredict
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (sat_inc_en(inc, &count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions; on resolution it drives the
// predictor update, flags mispredictions, flushes wrong-path entries and keeps stats.
module branch_resolve_queue #(
  parameter int unsigned ADDR_W = bp_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  branch_resolve_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           branch_count,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count
);

  import bp_pkg::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  // Entry layout comes from bp_pkg, so ADDR_W must track bp_pkg::ADDR_W.
  entry_t            mem_q [DEPTH];
  entry_t            rd_entry;

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;

  logic              full, empty;
  logic              push, pop, miss, hit;

  logic              upd_valid_q;
  logic [ADDR_W-1:0] upd_addr_q;
  logic              upd_result_q;
  logic              mispredict_q;

  assign full     = (occ_q == OccW'(DEPTH));
  assign empty    = (occ_q == '0);
  assign rd_entry = mem_q[rd_ptr_q];

  assign push = bus.pred_valid & ~full;
  assign pop  = bus.res_valid & ~empty;
  assign miss = pop & (rd_entry.taken ^ bus.res_taken);
  assign hit  = pop & ~miss;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    occ_d    = occ_q + OccW'(push) - OccW'(pop);
    // Everything younger than the mispredicted branch is wrong-path, including
    // a prediction arriving in the same cycle.
    if (miss) begin
      wr_ptr_d = rd_ptr_d;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      upd_valid_q  <= 1'b0;
      upd_addr_q   <= '0;
      upd_result_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      upd_valid_q  <= pop;
      mispredict_q <= miss;
      if (pop) begin
        upd_addr_q   <= rd_entry.addr;
        upd_result_q <= bus.res_taken;
      end
    end
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push && !miss) begin
      mem_q[wr_ptr_q] <= '{addr: bus.pred_addr, taken: bus.pred_taken};
    end
  end

  bp_sat_counter #(
    .CNT_W (CNT_W)
  ) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pop),
    .count (branch_count)
  );

  bp_sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .count (hit_count)
  );

  bp_sat_counter #(
    .CNT_W (CNT_W)
  ) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss),
    .count (miss_count)
  );

  assign bus.pred_ready = ~full;
  assign bus.res_ready  = ~empty;
  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_addr   = upd_addr_q;
  assign bus.upd_result = upd_result_q;
  assign bus.mispredict = mispredict_q;
  assign occupancy      = occ_q;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue sitting between the fetch-side prediction and the execute-side branch resolution.
- Captures each prediction from saturating_predictor together with its branch address.
- When the branch resolves, pops the oldest entry, compares it with the real outcome, and drives the predictor's update interface (cs/enable/branch_address/branch_result).
- Flags mispredictions, flushes younger speculative entries, and keeps hit/miss/branch statistics.

Parameters:
ADDR_W, 1, width of branch_address (matches saturating_predictor)
DEPTH, 4, number of in-flight predictions; power of two, >= 2
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
pred_valid  input  1  prediction offered this cycle
pred_addr  input  ADDR_W  branch address of the offered prediction
pred_taken  input  1  predicted direction (predictor's prediction output)
pred_ready  output  1  queue can accept a prediction (= not full), combinational
res_valid  input  1  oldest branch resolved this cycle
res_taken  input  1  actual outcome
res_ready  output  1  queue holds an entry to resolve (= not empty), combinational
upd_valid  output  1  predictor update strobe; drives predictor cs and enable
upd_addr  output  ADDR_W  address for the update (predictor branch_address)
upd_result  output  1  actual outcome for the update (predictor branch_result)
mispredict  output  1  one-cycle pulse: resolved outcome differed from the prediction
occupancy  output  $clog2(DEPTH)+1  number of valid entries
branch_count  output  CNT_W  resolved branches, saturating
hit_count  output  CNT_W  correct predictions, saturating
miss_count  output  CNT_W  mispredictions, saturating

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - Read pointer, write pointer and occupancy cleared to 0.
  - upd_valid=0, upd_addr=0, upd_result=0, mispredict=0.
  - All counters set to 0.
  - Any entries in flight are discarded.
  - Reset has priority over every other event in that cycle.
- Push:
  - Fires when pred_valid && pred_ready.
  - Writes {pred_addr, pred_taken} at the write pointer; the pointer advances mod DEPTH.
  - A push while full is ignored; nothing is stored.
- Pop:
  - Fires when res_valid && res_ready.
  - Reads the entry at the read pointer; the pointer advances mod DEPTH.
  - A res_valid while empty is ignored: no update, no counter change.
- Update outputs are registered, one cycle of latency. In the cycle after a pop:
  - upd_valid=1.
  - upd_addr = stored address.
  - upd_result = res_taken.
  - mispredict = stored prediction XOR res_taken.
- In cycles with no pop, upd_valid=0 and mispredict=0. upd_addr and upd_result hold their last values.
- Counters, updated at the same edge as the pop:
  - branch_count increments on every pop.
  - hit_count increments when the stored prediction equals res_taken; otherwise miss_count increments.
  - Each counter stops at 2^CNT_W-1 with no wrap. The other counters keep counting.
- Flush on misprediction:
  - At the pop edge, the queue is emptied: the write pointer is set to the post-pop read pointer and occupancy is 0.
  - A push in the same cycle is discarded, since it is on the wrong path.
- Simultaneous push and pop without misprediction:
  - Both complete and occupancy is unchanged.
  - When full, pred_ready=0, so the push is not accepted even if a pop occurs in that cycle.
- Occupancy:
  - Tracked explicitly so that full (occupancy==DEPTH) and empty (occupancy==0) are unambiguous at pointer wrap-around.
- No combinational path from res_valid to upd_* or mispredict.

Decomposition:
- Shared package bp_pkg:
  - Entry typedef {addr, taken}.
  - ADDR_W default.
  - Saturating-increment constant/function used by all counters.
- One natural sub-module: bp_sat_counter (CNT_W-wide saturating incrementer with sync reset), instantiated three times.
- The queue storage stays inline.

Test Plan:
- Reset check: hold rst for 2 cycles mid-traffic with occupancy=3 -> occupancy=0, res_ready=0, pred_ready=1, all counters 0, upd_valid=0.
- Fill and full:
  - Push 4 predictions (addr 0,1,0,1; taken 1,1,0,1) -> occupancy=4, pred_ready=0.
  - A 5th push is ignored; popping afterwards returns only the 4 originals.
- In-order correct resolve: resolve with taken 1,1,0,1 -> each pop is followed next cycle by upd_valid=1 with upd_addr 0,1,0,1, mispredict=0; final hit_count=4, miss_count=0, branch_count=4.
- Mispredict flush:
  - Queue holds 3 entries; the first has taken=1. Resolve it with res_taken=0 while pred_valid=1 in the same cycle.
  - Next cycle: mispredict=1, upd_result=0, occupancy=0, miss_count=1; the same-cycle push was dropped.
- Wrap-around with simultaneous push/pop: stream 10 pushes and 10 pops, overlapping each cycle, occupancy held at 2 -> pointers wrap and the updates come out in push order with no loss.
- Empty resolve and saturation:
  - res_valid with an empty queue -> no upd_valid, counters unchanged.
  - With CNT_W=2, perform 5 correct pops -> hit_count stops at 3, branch_count=3.
